// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-bus master: command encodings, FSM states,
// the register map of the attached register block and its reset values.
package reg_bus_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_POLL  = 2'b10,
        OP_RMW   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_POLL,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } state_e;

    localparam logic [9:0]  ADDR_DATA0       = 10'h000;
    localparam logic [9:0]  ADDR_DATA0_ALIAS = 10'h004;
    localparam logic [9:0]  ADDR_DATA1       = 10'h008;
    localparam logic [9:0]  ADDR_DATA1_ALIAS = 10'h00C;

    localparam logic [31:0] RST_DATA0 = 32'h0000_0000;
    localparam logic [31:0] RST_DATA1 = 32'hFFFF_FFFF;

    // Bits selected by mask come from the new value, the rest from the old one.
    function automatic logic [31:0] merge_bits(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/reg_bus_poll_cnt.sv
// 8-bit poll read counter; tc flags that the read being issued now is the last allowed one.
module reg_bus_poll_cnt #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (inc) begin
            count <= count + 8'd1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/reg_bus_master.sv
// Command-driven register-bus master: WRITE, READ, POLL-until-match and read-modify-write,
// each answered with a single response handshake.
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int unsigned POLL_MAX = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [9:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [31:0] cmd_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        wr_en,
    output logic        rd_en,
    output logic [9:0]  addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata
);

    state_e      state;
    state_e      state_nxt;
    logic [31:0] mask_q;
    logic        poll_tc;
    logic        poll_match;
    logic        misaligned;

    assign misaligned = (cmd_addr[1:0] != 2'b00);
    // wdata still holds the compare value while polling; it only changes for RMW.
    assign poll_match = ((rdata & mask_q) == (wdata & mask_q));

    reg_bus_poll_cnt #(.LIMIT(POLL_MAX)) u_poll_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state != S_POLL),
        .inc   (state == S_POLL),
        .tc    (poll_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes and handshakes decode from state alone so reset removes them at once.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (misaligned) begin
                        state_nxt = S_RESP;
                    end else begin
                        case (op_e'(cmd_op))
                            OP_WRITE: state_nxt = S_WR;
                            OP_READ:  state_nxt = S_RD;
                            OP_POLL:  state_nxt = S_POLL;
                            OP_RMW:   state_nxt = S_RMW_RD;
                            default:  state_nxt = S_IDLE;
                        endcase
                    end
                end
            end
            S_WR: begin
                wr_en     = 1'b1;
                state_nxt = S_RESP;
            end
            S_RD: begin
                rd_en     = 1'b1;
                state_nxt = S_RESP;
            end
            S_POLL: begin
                rd_en = 1'b1;
                if (poll_match || poll_tc) begin
                    state_nxt = S_RESP;
                end
            end
            S_RMW_RD: begin
                rd_en     = 1'b1;
                state_nxt = S_RMW_WR;
            end
            S_RMW_WR: begin
                wr_en     = 1'b1;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q   <= 32'd0;
            addr     <= 10'd0;
            wdata    <= 32'd0;
            rsp_data <= 32'd0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr     <= cmd_addr;
                        wdata    <= cmd_wdata;
                        mask_q   <= cmd_mask;
                        rsp_data <= 32'd0;
                        rsp_err  <= misaligned;
                    end
                end
                S_RD: rsp_data <= rdata;
                S_POLL: begin
                    if (poll_match || poll_tc) begin
                        rsp_data <= rdata;
                        rsp_err  <= !poll_match;
                    end
                end
                S_RMW_RD: wdata    <= merge_bits(rdata, wdata, mask_q);
                S_RMW_WR: rsp_data <= wdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench: reg_bus_master driving a two-register responder (DATA0/DATA1 with aliases).
module tb_reg_bus_master;
    import reg_bus_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [31:0] cmd_mask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        wr_en;
    logic        rd_en;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    int cmp_count  = 0;
    int fail_count = 0;

    int rd_total  = 0;
    int wr_total  = 0;
    int bad_total = 0;

    logic [31:0] data0;
    logic [31:0] data1;

    reg_bus_master #(.POLL_MAX(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_mask  (cmd_mask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register responder: addr[3] picks DATA1, addr[2] is an alias bit.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data0 <= RST_DATA0;
            data1 <= RST_DATA1;
        end else if (wr_en) begin
            if (addr[3]) data1 <= wdata;
            else         data0 <= wdata;
        end
    end
    assign rdata = addr[3] ? data1 : data0;

    // Strobe monitor, sampled mid-cycle; any strobe while idle/responding or overlapping is bad.
    always @(negedge clk) begin
        if (rd_en) rd_total++;
        if (wr_en) wr_total++;
        if ((rd_en && wr_en) || ((cmd_ready || rsp_valid) && (rd_en || wr_en))) bad_total++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one command, wait for its response (optionally stalling rsp_ready), report results.
    task automatic applyStimulus(input  logic [1:0]  op,
                                 input  logic [9:0]  a,
                                 input  logic [31:0] wd,
                                 input  logic [31:0] msk,
                                 input  int          hold,
                                 output logic [31:0] data,
                                 output logic        err,
                                 output int          lat,
                                 output int          rds,
                                 output int          wrs,
                                 output int          wait_cycles);
        int rd0;
        int wr0;
        int bad0;
        logic [31:0] held_data;
        logic        held_err;
        @(negedge clk);
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_mask  = msk;
        cmd_valid = 1'b1;
        wait_cycles = 0;
        while (!cmd_ready && wait_cycles < 50) begin
            @(negedge clk);
            wait_cycles++;
        end
        rd0 = rd_total;
        wr0 = wr_total;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 100);
        if (!rsp_valid) checkOutput("rsp_timeout", 32'(lat), 32'd0);
        data = rsp_data;
        err  = rsp_err;
        if (hold > 0) begin
            held_data = rsp_data;
            held_err  = rsp_err;
            bad0      = bad_total;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                checkOutput($sformatf("hold_valid%0d", i), {31'd0, rsp_valid}, 32'd1);
                checkOutput($sformatf("hold_data%0d", i), rsp_data, held_data);
                checkOutput($sformatf("hold_err%0d", i), {31'd0, rsp_err}, {31'd0, held_err});
                checkOutput($sformatf("hold_cmd_ready%0d", i), {31'd0, cmd_ready}, 32'd0);
            end
            checkOutput("hold_no_strobe", 32'(bad_total - bad0), 32'd0);
        end
        rds = rd_total - rd0;
        wrs = wr_total - wr0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        int          rds;
        int          wrs;
        int          wt;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = 10'd0;
        cmd_wdata = 32'd0;
        cmd_mask  = 32'd0;
        rsp_ready = 1'b0;

        #12;
        checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_strobes", {30'd0, rd_en, wr_en}, 32'd0);
        checkOutput("rst_addr", {22'd0, addr}, 32'd0);
        checkOutput("rst_wdata", wdata, 32'd0);
        checkOutput("rst_rsp", {rsp_data[30:0], rsp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(OP_READ, ADDR_DATA1, 32'd0, 32'd0, 0, d, e, lat, rds, wrs, wt);
        checkOutput("rd1_data", d, 32'hFFFF_FFFF);
        checkOutput("rd1_err", {31'd0, e}, 32'd0);
        checkOutput("rd1_lat", 32'(lat), 32'd2);
        checkOutput("rd1_rd_cycles", 32'(rds), 32'd1);
        checkOutput("rd1_wr_cycles", 32'(wrs), 32'd0);

        applyStimulus(OP_WRITE, ADDR_DATA0, 32'h0000_00D0, 32'd0, 0, d, e, lat, rds, wrs, wt);
        checkOutput("wr0_data", d, 32'd0);
        checkOutput("wr0_err", {31'd0, e}, 32'd0);
        checkOutput("wr0_lat", 32'(lat), 32'd2);
        checkOutput("wr0_wr_cycles", 32'(wrs), 32'd1);
        checkOutput("wr0_rd_cycles", 32'(rds), 32'd0);

        applyStimulus(OP_READ, ADDR_DATA0_ALIAS, 32'd0, 32'd0, 0, d, e, lat, rds, wrs, wt);
        checkOutput("rd_alias0_data", d, 32'h0000_00D0);
        checkOutput("b2b_accept_wait", 32'(wt), 32'd0);

        applyStimulus(OP_WRITE, 10'h002, 32'h1111_1111, 32'd0, 0, d, e, lat, rds, wrs, wt);
        checkOutput("misalign_err", {31'd0, e}, 32'd1);
        checkOutput("misalign_data", d, 32'd0);
        checkOutput("misalign_strobes", 32'(rds + wrs), 32'd0);
        checkOutput("misalign_lat", 32'(lat), 32'd1);

        applyStimulus(OP_RMW, ADDR_DATA1, 32'h0000_1234, 32'h0000_FFFF, 0, d, e, lat, rds, wrs, wt);
        checkOutput("rmw_data", d, 32'hFFFF_1234);
        checkOutput("rmw_err", {31'd0, e}, 32'd0);
        checkOutput("rmw_lat", 32'(lat), 32'd3);
        checkOutput("rmw_strobes", {16'(rds), 16'(wrs)}, {16'd1, 16'd1});

        applyStimulus(OP_READ, ADDR_DATA1_ALIAS, 32'd0, 32'd0, 0, d, e, lat, rds, wrs, wt);
        checkOutput("rd_alias1_data", d, 32'hFFFF_1234);

        applyStimulus(OP_POLL, ADDR_DATA0, 32'h0000_00D0, 32'h0000_00FF, 0, d, e, lat, rds, wrs, wt);
        checkOutput("poll_hit_err", {31'd0, e}, 32'd0);
        checkOutput("poll_hit_data", d, 32'h0000_00D0);
        checkOutput("poll_hit_reads", 32'(rds), 32'd1);
        checkOutput("poll_hit_lat", 32'(lat), 32'd2);

        applyStimulus(OP_POLL, ADDR_DATA0, 32'h0000_00AA, 32'h0000_00FF, 0, d, e, lat, rds, wrs, wt);
        checkOutput("poll_to_err", {31'd0, e}, 32'd1);
        checkOutput("poll_to_data", d, 32'h0000_00D0);
        checkOutput("poll_to_reads", 32'(rds), 32'd16);
        checkOutput("poll_to_lat", 32'(lat), 32'd17);
        checkOutput("poll_to_writes", 32'(wrs), 32'd0);

        applyStimulus(OP_READ, ADDR_DATA1, 32'd0, 32'd0, 5, d, e, lat, rds, wrs, wt);
        checkOutput("stall_data", d, 32'hFFFF_1234);

        // Reset in the middle of a POLL that would otherwise run to timeout.
        @(negedge clk);
        cmd_op    = OP_POLL;
        cmd_addr  = ADDR_DATA0;
        cmd_wdata = 32'h0000_00AA;
        cmd_mask  = 32'h0000_00FF;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midpoll_rd_en", {31'd0, rd_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_rd_en", {31'd0, rd_en}, 32'd0);
        checkOutput("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("release_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("release_rd_en", {31'd0, rd_en}, 32'd0);

        applyStimulus(OP_READ, ADDR_DATA0, 32'd0, 32'd0, 0, d, e, lat, rds, wrs, wt);
        checkOutput("post_abort_data", d, 32'h0000_0000);
        checkOutput("post_abort_accept_wait", 32'(wt), 32'd0);

        @(negedge clk);
        checkOutput("strobe_rules", 32'(bad_total), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
